// File: rtl/rc4_pkg.sv
// rc4_pkg -- definitions shared by the RC4 stream blocks (key schedule,
// PRGA stream, character checker).
//   S_AW      : S-box RAM address width
//   MSG_AW    : message ROM/RAM address width
//   K_W       : byte-index width (one extra bit so k can reach MSG_LEN)
//   MSG_LEN_DEFAULT : default number of message bytes per pass
//   state_t / ST_* : PRGA stream FSM state encoding
package rc4_pkg;

  localparam int S_AW            = 8;
  localparam int MSG_AW          = 5;
  localparam int K_W             = 6;
  localparam int MSG_LEN_DEFAULT = 32;

  typedef logic [3:0] state_t;

  localparam state_t ST_IDLE     = 4'd0;
  localparam state_t ST_RD_SI    = 4'd1;
  localparam state_t ST_WT_SI    = 4'd2;
  localparam state_t ST_RD_SJ    = 4'd3;
  localparam state_t ST_WT_SJ    = 4'd4;
  localparam state_t ST_WR_SI    = 4'd5;
  localparam state_t ST_WR_SJ    = 4'd6;
  localparam state_t ST_RD_F     = 4'd7;
  localparam state_t ST_WT_F     = 4'd8;
  localparam state_t ST_WR_DEC   = 4'd9;
  localparam state_t ST_PRESENT  = 4'd10;
  localparam state_t ST_WAIT_ACK = 4'd11;
  localparam state_t ST_DONE     = 4'd12;

endpackage

// File: rtl/rc4_prga_stream.sv
// rc4_prga_stream -- RC4 pseudo-random generation and decryption of one
// message pass, one byte at a time, handshaked with a character checker.
//
// Ports
//   clok           : clock, rising edge
//   resetm         : asynchronous active-low reset
//   start          : pulse in IDLE, begins a pass (S RAM already scheduled)
//   start_over     : abort from any state back to IDLE
//   compared_char  : checker accepted char_out (only honoured in WAIT_ACK)
//   s_addr/s_wdata/s_wren/s_rdata : S RAM port, read data 1 cycle after addr
//   enc_addr/enc_rdata : encrypted message ROM, data 1 cycle after addr
//   dec_addr/dec_wdata/dec_wren   : decrypted message RAM write port
//   new_char       : one-cycle pulse, char_out holds a fresh byte
//   char_out       : decrypted byte k, held until the next new_char
//   char_count     : current byte index k (MSG_LEN once done)
//   pass_done      : level, every byte produced and accepted
//
// All outputs are registers. Each one is loaded on the edge that enters
// the state in which it must be visible, so a RAM address presented in
// RD_xx is answered during the following WT_xx cycle.
module rc4_prga_stream
  import rc4_pkg::*;
#(
  parameter int MSG_LEN = MSG_LEN_DEFAULT
) (
  input  logic              clok,
  input  logic              resetm,
  input  logic              start,
  input  logic              start_over,
  input  logic              compared_char,
  output logic [S_AW-1:0]   s_addr,
  output logic [7:0]        s_wdata,
  output logic              s_wren,
  input  logic [7:0]        s_rdata,
  output logic [MSG_AW-1:0] enc_addr,
  input  logic [7:0]        enc_rdata,
  output logic [MSG_AW-1:0] dec_addr,
  output logic [7:0]        dec_wdata,
  output logic              dec_wren,
  output logic              new_char,
  output logic [7:0]        char_out,
  output logic [K_W-1:0]    char_count,
  output logic              pass_done
);

  state_t         state;
  logic [7:0]     i;
  logic [7:0]     j;
  logic [7:0]     si;
  logic [7:0]     sj;
  logic [7:0]     f;
  logic [7:0]     enc_q;
  logic [K_W-1:0] k;
  logic [K_W-1:0] k_inc;

  assign k_inc      = k + 1'b1;
  assign char_count = k;

  always_ff @(posedge clok or negedge resetm) begin
    if (!resetm) begin
      state     <= ST_IDLE;
      i         <= '0;
      j         <= '0;
      si        <= '0;
      sj        <= '0;
      f         <= '0;
      enc_q     <= '0;
      k         <= '0;
      s_addr    <= '0;
      s_wdata   <= '0;
      s_wren    <= 1'b0;
      enc_addr  <= '0;
      dec_addr  <= '0;
      dec_wdata <= '0;
      dec_wren  <= 1'b0;
      new_char  <= 1'b0;
      char_out  <= '0;
      pass_done <= 1'b0;
    end else begin
      // Strobes are single-cycle unless a state explicitly re-arms them.
      s_wren   <= 1'b0;
      dec_wren <= 1'b0;
      new_char <= 1'b0;

      if (start_over) begin
        // Abort wins over everything; strobes already cleared above so no
        // RAM write follows the abort.
        state     <= ST_IDLE;
        pass_done <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start) begin
              // i, j, k restart at 0; i is pre-incremented for the first read.
              i      <= 8'd1;
              j      <= '0;
              k      <= '0;
              s_addr <= 8'd1;
              state  <= ST_RD_SI;
            end
          end
          ST_RD_SI: state <= ST_WT_SI;
          ST_WT_SI: begin
            si     <= s_rdata;
            j      <= j + s_rdata;
            s_addr <= j + s_rdata;
            state  <= ST_RD_SJ;
          end
          ST_RD_SJ: state <= ST_WT_SJ;
          ST_WT_SJ: begin
            // Swap step 1: S[i] <= S[j].
            sj      <= s_rdata;
            s_addr  <= i;
            s_wdata <= s_rdata;
            s_wren  <= 1'b1;
            state   <= ST_WR_SI;
          end
          ST_WR_SI: begin
            // Swap step 2: S[j] <= old S[i].
            s_addr  <= j;
            s_wdata <= si;
            s_wren  <= 1'b1;
            state   <= ST_WR_SJ;
          end
          ST_WR_SJ: begin
            // Keystream lookup and ciphertext fetch share one wait cycle.
            s_addr   <= si + sj;
            enc_addr <= k[MSG_AW-1:0];
            state    <= ST_RD_F;
          end
          ST_RD_F: state <= ST_WT_F;
          ST_WT_F: begin
            f         <= s_rdata;
            enc_q     <= enc_rdata;
            dec_addr  <= k[MSG_AW-1:0];
            dec_wdata <= s_rdata ^ enc_rdata;
            dec_wren  <= 1'b1;
            state     <= ST_WR_DEC;
          end
          ST_WR_DEC: begin
            char_out <= f ^ enc_q;
            new_char <= 1'b1;
            state    <= ST_PRESENT;
          end
          ST_PRESENT: state <= ST_WAIT_ACK;
          ST_WAIT_ACK: begin
            if (compared_char) begin
              k <= k_inc;
              if (k_inc == K_W'(MSG_LEN)) begin
                pass_done <= 1'b1;
                state     <= ST_DONE;
              end else begin
                i      <= i + 8'd1;
                s_addr <= i + 8'd1;
                state  <= ST_RD_SI;
              end
            end
          end
          ST_DONE: state <= ST_DONE;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rc4_prga_stream.sv
// tb_rc4_prga_stream -- directed bench for rc4_prga_stream. Models the S RAM,
// encrypted ROM and decrypted RAM; the "key schedule" loads S[x]=x.
module tb_rc4_prga_stream;

  logic       clok = 1'b0;
  logic       resetm;
  logic       start;
  logic       start_over;
  logic       compared_char;
  logic [7:0] s_addr;
  logic [7:0] s_wdata;
  logic       s_wren;
  logic [7:0] s_rdata;
  logic [4:0] enc_addr;
  logic [7:0] enc_rdata;
  logic [4:0] dec_addr;
  logic [7:0] dec_wdata;
  logic       dec_wren;
  logic       new_char;
  logic [7:0] char_out;
  logic [5:0] char_count;
  logic       pass_done;

  always #5 clok = ~clok;

  rc4_prga_stream #(.MSG_LEN(32)) dut (
    .clok(clok), .resetm(resetm), .start(start), .start_over(start_over),
    .compared_char(compared_char),
    .s_addr(s_addr), .s_wdata(s_wdata), .s_wren(s_wren), .s_rdata(s_rdata),
    .enc_addr(enc_addr), .enc_rdata(enc_rdata),
    .dec_addr(dec_addr), .dec_wdata(dec_wdata), .dec_wren(dec_wren),
    .new_char(new_char), .char_out(char_out), .char_count(char_count),
    .pass_done(pass_done)
  );

  // Memory models and event counters (single writer: this block).
  logic [7:0]  s_mem   [256];
  logic [7:0]  enc_mem [32];
  logic [7:0]  dec_mem [32];
  logic [31:0] dec_seen = '0;
  logic        ks_req = 1'b0;
  int          s_wr_cnt = 0;
  int          dec_wr_cnt = 0;
  int          nc_cnt = 0;

  always @(posedge clok) begin
    if (ks_req) begin
      for (int x = 0; x < 256; x++) s_mem[x] <= 8'(x);
      dec_seen <= '0;
    end else if (s_wren) begin
      s_mem[s_addr] <= s_wdata;
      s_wr_cnt <= s_wr_cnt + 1;
    end
    s_rdata   <= s_mem[s_addr];
    enc_rdata <= enc_mem[enc_addr];
    if (dec_wren) begin
      dec_mem[dec_addr]  <= dec_wdata;
      dec_seen[dec_addr] <= 1'b1;
      dec_wr_cnt <= dec_wr_cnt + 1;
    end
    if (new_char) nc_cnt <= nc_cnt + 1;
  end

  // Reference RC4 PRGA model.
  logic [7:0] m_s [256];
  logic [7:0] mi, mj;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_init();
    for (int x = 0; x < 256; x++) m_s[x] = 8'(x);
    mi = 8'd0;
    mj = 8'd0;
  endtask

  task automatic model_step(output logic [7:0] fo);
    logic [7:0] t;
    logic [7:0] idx;
    mi = mi + 8'd1;
    t  = m_s[mi];
    mj = mj + t;
    m_s[mi] = m_s[mj];
    m_s[mj] = t;
    idx = m_s[mi] + m_s[mj];
    fo = m_s[idx];
  endtask

  task automatic key_schedule();
    ks_req = 1'b1;
    @(negedge clok);
    ks_req = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clok);
    start = 1'b0;
  endtask

  task automatic pulse_ack();
    compared_char = 1'b1;
    @(negedge clok);
    compared_char = 1'b0;
  endtask

  // Called right after start/ack was sampled; checks latency, byte, index
  // and the dec RAM write, then steps into WAIT_ACK.
  task automatic do_byte(input string tag, input logic [7:0] exp_ch, input logic [5:0] exp_k);
    int lat;
    lat = 1;
    while (!new_char && lat < 40) begin
      @(negedge clok);
      lat++;
    end
    chk({tag, " latency"}, 32'(lat), 32'd10);
    chk({tag, " char_out"}, {24'd0, char_out}, {24'd0, exp_ch});
    chk({tag, " char_count"}, {26'd0, char_count}, {26'd0, exp_k});
    chk({tag, " dec_mem"}, {24'd0, dec_mem[exp_k[4:0]]}, {24'd0, exp_ch});
    $display("byte %s k=%0d char_out=%02h latency=%0d", tag, exp_k, char_out, lat);
    @(negedge clok);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s_snap, d_snap, n_snap, lat;
    logic [7:0] fx;

    resetm = 1'b0; start = 1'b0; start_over = 1'b0; compared_char = 1'b0;
    for (int x = 0; x < 32; x++) enc_mem[x] = 8'h00;
    repeat (3) @(negedge clok);
    chk("rst s_wren", {31'd0, s_wren}, 32'd0);
    chk("rst dec_wren", {31'd0, dec_wren}, 32'd0);
    chk("rst new_char", {31'd0, new_char}, 32'd0);
    chk("rst pass_done", {31'd0, pass_done}, 32'd0);
    chk("rst char_count", {26'd0, char_count}, 32'd0);
    chk("rst char_out", {24'd0, char_out}, 32'd0);
    chk("rst s_addr", {24'd0, s_addr}, 32'd0);
    chk("rst dec_wdata", {24'd0, dec_wdata}, 32'd0);
    $display("reset state checked");
    resetm = 1'b1;
    @(negedge clok);

    // Identity S, zero ciphertext: hand-computed keystream 02 05 07 0d 0d 17.
    key_schedule();
    pulse_start();
    do_byte("b0", 8'h02, 6'd0);
    pulse_ack();
    do_byte("b1", 8'h05, 6'd1);
    chk("S[2] after b1", {24'd0, s_mem[2]}, 32'd3);
    chk("S[3] after b1", {24'd0, s_mem[3]}, 32'd2);
    pulse_ack();
    do_byte("b2", 8'h07, 6'd2);
    pulse_ack();
    do_byte("b3", 8'h0d, 6'd3);

    // Withhold the acknowledge: nothing may move.
    s_snap = s_wr_cnt; d_snap = dec_wr_cnt; n_snap = nc_cnt;
    repeat (50) @(negedge clok);
    chk("hold new_char cnt", 32'(nc_cnt), 32'(n_snap));
    chk("hold dec writes", 32'(dec_wr_cnt), 32'(d_snap));
    chk("hold s writes", 32'(s_wr_cnt), 32'(s_snap));
    chk("hold char_out", {24'd0, char_out}, 32'h0d);
    chk("hold char_count", {26'd0, char_count}, 32'd3);
    $display("withheld ack for 50 cycles at k=3");
    pulse_ack();
    do_byte("b4", 8'h0d, 6'd4);
    pulse_ack();
    do_byte("b5", 8'h17, 6'd5);

    // start_over together with compared_char at k=5.
    s_snap = s_wr_cnt; d_snap = dec_wr_cnt; n_snap = nc_cnt;
    start_over = 1'b1; compared_char = 1'b1;
    @(negedge clok);
    start_over = 1'b0; compared_char = 1'b0;
    chk("abort char_count", {26'd0, char_count}, 32'd5);
    chk("abort s_wren", {31'd0, s_wren}, 32'd0);
    chk("abort dec_wren", {31'd0, dec_wren}, 32'd0);
    repeat (20) @(negedge clok);
    chk("abort s writes", 32'(s_wr_cnt), 32'(s_snap));
    chk("abort dec writes", 32'(dec_wr_cnt), 32'(d_snap));
    chk("abort new_char cnt", 32'(nc_cnt), 32'(n_snap));
    $display("start_over with ack at k=5 handled");

    // Full 32-byte pass against the reference model.
    key_schedule();
    model_init();
    d_snap = dec_wr_cnt; n_snap = nc_cnt;
    pulse_start();
    for (int kk = 0; kk < 32; kk++) begin
      model_step(fx);
      do_byte("full", fx, 6'(kk));
      pulse_ack();
    end
    chk("full pass_done", {31'd0, pass_done}, 32'd1);
    chk("full char_count", {26'd0, char_count}, 32'd32);
    chk("full new_char cnt", 32'(nc_cnt - n_snap), 32'd32);
    chk("full dec writes", 32'(dec_wr_cnt - d_snap), 32'd32);
    chk("full dec addrs", dec_seen, 32'hFFFF_FFFF);
    $display("full pass done: new_char=%0d dec_writes=%0d", nc_cnt - n_snap, dec_wr_cnt - d_snap);

    // start and compared_char in DONE are ignored; start_over leaves.
    s_snap = s_wr_cnt; n_snap = nc_cnt;
    start = 1'b1; compared_char = 1'b1;
    @(negedge clok);
    start = 1'b0; compared_char = 1'b0;
    repeat (15) @(negedge clok);
    chk("done pass_done", {31'd0, pass_done}, 32'd1);
    chk("done char_count", {26'd0, char_count}, 32'd32);
    chk("done new_char cnt", 32'(nc_cnt), 32'(n_snap));
    chk("done s writes", 32'(s_wr_cnt), 32'(s_snap));
    start_over = 1'b1;
    @(negedge clok);
    start_over = 1'b0;
    chk("exit pass_done", {31'd0, pass_done}, 32'd0);
    $display("DONE state holds, start_over returns to idle");

    // Reset asserted during WR_SI, then a fresh pass with nonzero ciphertext.
    key_schedule();
    enc_mem[0] = 8'hA5;
    pulse_start();
    lat = 1;
    while (!s_wren && lat < 40) begin
      @(negedge clok);
      lat++;
    end
    chk("first S write cycle", 32'(lat), 32'd5);
    #2 resetm = 1'b0;
    #1;
    chk("async rst s_wren", {31'd0, s_wren}, 32'd0);
    chk("async rst s_addr", {24'd0, s_addr}, 32'd0);
    chk("async rst s_wdata", {24'd0, s_wdata}, 32'd0);
    chk("async rst char_count", {26'd0, char_count}, 32'd0);
    @(negedge clok);
    resetm = 1'b1;
    @(negedge clok);
    key_schedule();
    pulse_start();
    do_byte("after_rst", 8'hA7, 6'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
